// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - controller state encodings (RUN/STALL/FLUSH, code 3 unused)
//   - scoreboard entry layout {valid, rd, memr}
//   - default register-address width
// The scoreboard entry carries rd at REG_AW_MAX bits so a single typedef can
// serve every REG_AW up to that width; narrower addresses are zero-extended.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 6;
    localparam int REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  memr;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Three-entry in-flight writer list (EX -> MEM -> WB) plus source-match logic.
// The list shifts every cycle; the EX slot takes the ID instruction only when
// it issues, otherwise an invalid entry.
//
// Build option: HAZ_FORWARD_EN
//   defined   : only a load in EX that matches a source is a hazard
//   undefined : a match against any valid EX/MEM/WB entry is a hazard
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   issue                   ID instruction enters EX this cycle
//   id_valid                ID holds a real instruction
//   id_rs/id_rt             source registers, id_use_rs/id_use_rt qualify them
//   id_rd/id_regw/id_memr   destination info captured on issue
//   hazard                  combinational hazard seen at ID
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regw,
    input  logic              id_memr,
    output logic              hazard
);

    sb_entry_t sb_q [3];
    sb_entry_t sb_d [3];
    logic [2:0] match;
    logic       unused_memr;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    always_comb begin
        sb_d[0].valid = issue & id_regw;
        sb_d[0].rd    = REG_AW_MAX'(id_rd);
        sb_d[0].memr  = id_memr;
        sb_d[1]       = sb_q[0];
        sb_d[2]       = sb_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // Register 0 is an ordinary register here: no special-casing.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            assign match[gi] = sb_q[gi].valid &
                ((id_use_rs & (sb_q[gi].rd == REG_AW_MAX'(id_rs))) |
                 (id_use_rt & (sb_q[gi].rd == REG_AW_MAX'(id_rt))));
        end
    endgenerate

`ifdef HAZ_FORWARD_EN
    // Bypass network covers everything except a load still in EX.
    assign hazard = id_valid & match[0] & sb_q[0].memr;
`else
    // No bypassing: wait until the writer has left WB.
    assign hazard = id_valid & (|match);
`endif

    // The oldest memr bits are not needed by either hazard rule.
    assign unused_memr = sb_q[1].memr ^ sb_q[2].memr;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for an in-order pipeline. Detects data hazards at ID
// against a three-entry writer scoreboard, holds PC and IF/ID on a stall, kills
// IF/ID for FLUSH_LEN cycles after an EX redirect, and counts stall cycles and
// redirect events with saturating counters.
//
// Build option: HAZ_FORWARD_EN (see hazard_scoreboard) selects load-use-only
// hazards; the default build stalls until the writer leaves WB.
//
// Parameters: REG_AW (register address width), FLUSH_LEN (1..3 kill cycles),
//             CNT_W (performance counter width)
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_valid, id_rs, id_rt,
//   id_use_rs, id_use_rt, id_rd,
//   id_regw, id_memr                 decoded ID instruction
//   ex_redirect                      taken branch/jump resolved in EX
//   pc_hold, ifid_hold               freeze PC and IF/ID
//   idex_bubble                      load a NOP into ID/EX
//   ifid_flush                       clear IF/ID
//   state                            0 RUN, 1 STALL, 2 FLUSH
//   stall_cnt, flush_cnt             saturating event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regw,
    input  logic              id_memr,
    input  logic              ex_redirect,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Counter holds the FLUSH cycles still to go after the current one.
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic is_stall, is_flush, is_run;
    logic killing, stalling, issue;

    // Unused code 3 falls into "run".
    assign is_stall = (state_q == ST_STALL);
    assign is_flush = (state_q == ST_FLUSH);
    assign is_run   = ~is_stall & ~is_flush;

    // A redirect always wins over a hazard in the same cycle.
    assign killing  = ex_redirect | is_flush;
    assign stalling = hazard & ~killing;
    assign issue    = id_valid & ~hazard & is_run & ~ex_redirect;

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_rd     (id_rd),
        .id_regw   (id_regw),
        .id_memr   (id_memr),
        .hazard    (hazard)
    );

    // Zero-latency outputs; gated by rst_n so a redirect seen during reset
    // cannot leak a flush.
    assign pc_hold     = rst_n & stalling;
    assign ifid_hold   = rst_n & stalling;
    assign idex_bubble = rst_n & (stalling | killing);
    assign ifid_flush  = rst_n & killing;
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_STALL: begin
                if (ex_redirect) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end else if (!hazard) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (ex_redirect) begin
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            default: begin
                if (ex_redirect) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end else if (hazard) begin
                    state_d = ST_STALL;
                end
            end
        endcase

        if (pc_hold && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (FLUSH_LEN=2, CNT_W=16). The
// reference model keeps a list of in-flight writers by age and a mode/
// remaining-flush-cycles pair, updated once per clock from the current inputs.
// Build with or without HAZ_FORWARD_EN; expectations follow the same macro.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_AW    = 6;
    localparam int FLUSH_LEN = 2;
    localparam int CNT_W     = 16;
    localparam int CMAX      = 65535;

`ifdef HAZ_FORWARD_EN
    localparam int EXP_LOAD_USE = 1;
    localparam int EXP_ALU_USE  = 0;
`else
    localparam int EXP_LOAD_USE = 3;
    localparam int EXP_ALU_USE  = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid, id_use_rs, id_use_rt, id_regw, id_memr, ex_redirect;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              pc_hold, ifid_hold, idex_bubble, ifid_flush;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl #(
        .REG_AW    (REG_AW),
        .FLUSH_LEN (FLUSH_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_regw     (id_regw),
        .id_memr     (id_memr),
        .ex_redirect (ex_redirect),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // age 0 = youngest writer (one cycle past ID), age 2 = oldest kept
    bit w_valid [3];
    int w_rd    [3];
    bit w_load  [3];
    int m_mode;      // 0 run, 1 stall, 2 flush
    int m_left;      // flush cycles remaining including the current one
    int m_stall, m_flush;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            w_valid[i] = 0; w_rd[i] = 0; w_load[i] = 0;
        end
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic bit reads(int r);
        return (id_use_rs && int'(id_rs) == r) || (id_use_rt && int'(id_rt) == r);
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        if (!id_valid) return 0;
`ifdef HAZ_FORWARD_EN
        h = w_valid[0] && w_load[0] && reads(w_rd[0]);
`else
        for (int i = 0; i < 3; i++) if (w_valid[i] && reads(w_rd[i])) h = 1;
`endif
        return h;
    endfunction

    // {pc_hold, ifid_hold, idex_bubble, ifid_flush, state}
    function automatic logic [5:0] m_expect();
        bit kill, hold;
        if (!rst_n) return 6'd0;
        kill = ex_redirect || m_mode == 2;
        hold = m_hazard() && !kill;
        return {hold, hold, hold || kill, kill, 2'(m_mode)};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {pc_hold, ifid_hold, idex_bubble, ifid_flush, state};
    endfunction

    task automatic model_tick();
        bit hz, hold, iss;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hz   = m_hazard();
        hold = hz && !(ex_redirect || m_mode == 2);
        iss  = id_valid && !hz && m_mode == 0 && !ex_redirect;
        if (hold && m_stall < CMAX) m_stall++;
        if (ex_redirect && m_flush < CMAX) m_flush++;
        case (m_mode)
            0: if (ex_redirect) begin m_mode = 2; m_left = FLUSH_LEN; end
               else if (hz) m_mode = 1;
            1: if (ex_redirect) begin m_mode = 2; m_left = FLUSH_LEN; end
               else if (!hz) m_mode = 0;
            default: if (ex_redirect) m_left = FLUSH_LEN;
                     else begin m_left--; if (m_left == 0) m_mode = 0; end
        endcase
        for (int i = 2; i > 0; i--) begin
            w_valid[i] = w_valid[i-1]; w_rd[i] = w_rd[i-1]; w_load[i] = w_load[i-1];
        end
        w_valid[0] = iss && id_regw;
        w_rd[0]    = int'(id_rd);
        w_load[0]  = id_memr;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                          input bit urt, input int rd, input bit w, input bit m);
        id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
        id_use_rs = urs; id_use_rt = urt; id_rd = REG_AW'(rd);
        id_regw = w; id_memr = m;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        set_id(1, 1, 1, 1, 1, 1, 1, 1);
        ex_redirect = 1;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (obs_vec() !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000", obs_vec());
        end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        idle();
        rst_n = 1;
        #1;
        checks++;
        if (state !== 2'd0 || obs_vec() !== m_expect()) begin
            failures++;
            $display("FAIL reset_release: got %b expected %b", obs_vec(), m_expect());
        end
        tick();
    endtask

    task automatic test_dependency();
        int seen;
        do_reset();
        // load r5 followed by a reader of r5
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        seen = 0;
        set_id(1, 5, 2, 1, 1, 9, 1, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (obs_vec() !== m_expect()) begin
                failures++;
                $display("FAIL load_use_c%0d: got %b expected %b", c, obs_vec(), m_expect());
            end
            seen += int'(pc_hold);
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (seen != EXP_LOAD_USE || stall_cnt !== CNT_W'(EXP_LOAD_USE)) begin
            failures++;
            $display("FAIL load_use_count: got %0d cycles cnt=%0d expected %0d", seen, stall_cnt, EXP_LOAD_USE);
        end
        // ALU writer r7 followed by a reader of r7 through rt
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick();
        seen = 0;
        set_id(1, 3, 7, 0, 1, 10, 1, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (obs_vec() !== m_expect()) begin
                failures++;
                $display("FAIL alu_use_c%0d: got %b expected %b", c, obs_vec(), m_expect());
            end
            seen += int'(pc_hold);
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (seen != EXP_ALU_USE || stall_cnt !== CNT_W'(EXP_LOAD_USE + EXP_ALU_USE)) begin
            failures++;
            $display("FAIL alu_use_count: got %0d cycles cnt=%0d expected %0d", seen, stall_cnt, EXP_ALU_USE);
        end
    endtask

    task automatic test_redirect_in_stall();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        #1;
        checks++;
        if (pc_hold !== 1'b1) begin
            failures++;
            $display("FAIL stall_entry: pc_hold got %b expected 1", pc_hold);
        end
        tick();
        ex_redirect = 1;
        #1;
        checks++;
        if ({ifid_flush, idex_bubble, pc_hold, state} !== 5'b11001) begin
            failures++;
            $display("FAIL redirect_in_stall: got %b expected 11001", {ifid_flush, idex_bubble, pc_hold, state});
        end
        tick();
        ex_redirect = 0;
        #1;
        checks++;
        if (state !== 2'd2 || flush_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL stall_to_flush: state %0d flush_cnt %0d expected 2/1", state, flush_cnt);
        end
        idle();
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_flush_reload();
        int fl;
        do_reset();
        ex_redirect = 1;
        tick();
        #1;
        checks++;
        if (state !== 2'd2 || ifid_flush !== 1'b1) begin
            failures++;
            $display("FAIL flush_first: state %0d flush %b expected 2/1", state, ifid_flush);
        end
        tick();
        ex_redirect = 0;
        fl = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (obs_vec() !== m_expect()) begin
                failures++;
                $display("FAIL flush_reload_c%0d: got %b expected %b", c, obs_vec(), m_expect());
            end
            if (state == 2'd2) fl++;
            tick();
        end
        checks++;
        if (fl != 2 || flush_cnt !== CNT_W'(2) || state !== 2'd0) begin
            failures++;
            $display("FAIL flush_reload: %0d cycles flush_cnt %0d state %0d expected 2/2/0", fl, flush_cnt, state);
        end
    endtask

    task automatic test_reset_mid_stall();
        int seen;
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 5, 1, 1, 6, 1, 0);
        tick();
        #1;
        checks++;
        if (obs_vec() !== m_expect() || state !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset_stall: got %b expected %b", obs_vec(), m_expect());
        end
        #1;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 6'd0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset: got %b cnt %0d/%0d expected 000000 0/0", obs_vec(), stall_cnt, flush_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            seen += int'(pc_hold);
            tick();
        end
        checks++;
        if (seen != 0 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL post_reset_nostall: got %0d stalls cnt %0d expected 0/0", seen, stall_cnt);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            set_id($urandom_range(3) != 0, $urandom_range(3), $urandom_range(3),
                   $urandom_range(1), $urandom_range(1), $urandom_range(3),
                   $urandom_range(1), $urandom_range(2) == 0);
            ex_redirect = ($urandom_range(11) == 0);
            #1;
            checks++;
            if (obs_vec() !== m_expect() || stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_c%0d: got %b %0d/%0d expected %b %0d/%0d",
                             c, obs_vec(), stall_cnt, flush_cnt, m_expect(), m_stall, m_flush);
                bad++;
            end
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_stall_saturate();
        do_reset();
        force dut.stall_cnt_q = CNT_W'(CMAX - 5);
        #1;
        release dut.stall_cnt_q;
        m_stall = CMAX - 5;
        for (int r = 0; r < 8; r++) begin
            set_id(1, 0, 0, 0, 0, 4, 1, 1);
            tick();
            set_id(1, 4, 0, 1, 0, 8, 1, 0);
            for (int c = 0; c < 5; c++) begin
                #1;
                checks++;
                if (stall_cnt !== CNT_W'(m_stall) || obs_vec() !== m_expect()) begin
                    failures++;
                    $display("FAIL sat_r%0d_c%0d: got %0d %b expected %0d %b",
                             r, c, stall_cnt, obs_vec(), m_stall, m_expect());
                end
                tick();
            end
            idle();
            for (int c = 0; c < 3; c++) tick();
        end
        checks++;
        if (stall_cnt !== CNT_W'(CMAX)) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt, CMAX);
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_dependency();
        test_redirect_in_stall();
        test_flush_reload();
        test_reset_mid_stall();
        test_random();
        test_stall_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_AW, 6, register-address width; FLUSH_LEN, 1, kill cycles per redirect (1..3); CNT_W, 16, performance-counter width.
REQ-002 Ports SHALL be:
- clk, in, 1, rising-edge clock
- rst_n, in, 1, asynchronous active-low reset
- id_valid, in, 1, ID holds a real instruction
- id_rs, in, REG_AW, ID source register 1
- id_rt, in, REG_AW, ID source register 2
- id_use_rs, in, 1, id_rs is read
- id_use_rt, in, 1, id_rt is read
- id_rd, in, REG_AW, ID destination register
- id_regw, in, 1, ID instruction writes id_rd
- id_memr, in, 1, ID instruction is a load
- ex_redirect, in, 1, EX resolved taken branch/jump
- pc_hold, out, 1, freeze PC
- ifid_hold, out, 1, freeze IF/ID buffer
- idex_bubble, out, 1, load NOP into ID/EX buffer
- ifid_flush, out, 1, clear IF/ID buffer
- state, out, 2, FSM state code
- stall_cnt, out, CNT_W, stall cycles
- flush_cnt, out, CNT_W, redirect events

Function
REQ-003 Scoreboard SHALL hold three entries EX, MEM, WB, each {valid, rd, memr}, shifting EX->MEM->WB every cycle; WB's old content is dropped.
REQ-004 EX entry SHALL load {id_regw, id_rd, id_memr} only on issue (id_valid, no hazard, state RUN, no ex_redirect); otherwise it SHALL load valid=0.
REQ-005 Source match SHALL be (id_use_rs and id_rs==entry.rd) or (id_use_rt and id_rt==entry.rd) against a valid entry; register 0 is not special.
REQ-006 Hazard SHALL be id_valid and a source match per the Configuration rules.
REQ-007 FSM states SHALL be RUN=0, STALL=1, FLUSH=2; code 3 unused, decoded as RUN.
REQ-008 RUN->FLUSH on ex_redirect; RUN->STALL on hazard without ex_redirect; else stay RUN.
REQ-009 STALL->FLUSH on ex_redirect; STALL->RUN when hazard clears; else stay STALL.
REQ-010 FLUSH SHALL last exactly FLUSH_LEN cycles counted by an internal counter, then ->RUN; ex_redirect during FLUSH SHALL reload the counter.
REQ-011 Outputs SHALL be combinational from state and hazard: stall (hazard, not redirecting) -> pc_hold=ifid_hold=idex_bubble=1; redirect or FLUSH -> ifid_flush=idex_bubble=1 and pc_hold=ifid_hold=0.
REQ-012 ex_redirect SHALL take priority over hazard in the same cycle.
REQ-013 stall_cnt SHALL increment on each cycle with pc_hold=1; flush_cnt SHALL increment on each ex_redirect; both SHALL saturate at all-ones.
REQ-014 Stall latency SHALL be zero cycles: outputs assert in the same cycle the hazard is visible at ID.

Reset
REQ-015 rst_n low SHALL asynchronously set state=RUN, all scoreboard valid=0, flush counter=0, stall_cnt=0, flush_cnt=0.
REQ-016 During reset all hold/bubble/flush outputs SHALL be 0; reset release mid-stall resumes from RUN with an empty scoreboard.

Configuration
REQ-017 Macro HAZ_FORWARD_EN defined: hazard SHALL be a match on the EX entry only when that entry has memr=1 (load-use, exactly one stall cycle).
REQ-018 HAZ_FORWARD_EN undefined: hazard SHALL be a match on any of EX, MEM, WB entries (stall until writer leaves WB).

Structure
REQ-019 Shared package SHALL hold state encodings, the scoreboard-entry typedef and the REG_AW default.
REQ-020 Sub-module hazard_scoreboard SHALL contain the three-entry shift register and match logic; FSM and counters stay in the top.

Verification
REQ-021 Forwarding on: load r5, then add reading r5 -> exactly 1 cycle pc_hold=1, stall_cnt=1.
REQ-022 Forwarding off: add writes r7, next instruction reads r7 -> 3 stall cycles, stall_cnt=3.
REQ-023 ex_redirect while STALL -> same cycle ifid_flush=1, idex_bubble=1, pc_hold=0, state FLUSH next cycle, flush_cnt=1.
REQ-024 FLUSH_LEN=2, second ex_redirect in first FLUSH cycle -> FLUSH persists 2 more cycles, flush_cnt=2.
REQ-025 rst_n low mid-STALL -> outputs 0 immediately, state=0, counters=0, no stall after release.
REQ-026 stall_cnt preloaded near max by 70000 forced stall cycles with CNT_W=16 -> holds at 65535.
